// File: rtl/rr_arb_pkg.sv
// Shared types and defaults for the round-robin index arbiter.
// The optional grant-lock feature is selected with the RR_ARB_LOCK_EN macro
// in rr_arb_idx; nothing in this package depends on it.
package rr_arb_pkg;

  // Arbiter control state: waiting for any request, or holding a grant.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } rr_arb_state_t;

  // Default number of requesters.
  localparam int RR_ARB_NUM_REQ = 16;

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational rotating-priority search: starting at ptr and wrapping at
// NUM_REQ-1, returns the first set request bit as a binary index.
// idx is only meaningful when any is high; it is always < NUM_REQ.
module rr_arb_pick
  import rr_arb_pkg::*;
#(
  parameter int NUM_REQ = RR_ARB_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Walk the search order backwards so the earliest hit overwrites later ones.
  always_comb begin
    any      = |req;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand     = (int'(ptr) + i) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (req[cand_idx]) idx = cand_idx;
    end
  end

endmodule

// File: rtl/rr_arb_idx.sv
// Round-robin arbiter presenting the winner as a registered binary index
// with a valid/ready handshake; feeds a binary-to-one-hot decoder.
// Optional feature: define RR_ARB_LOCK_EN to add lock_i, which keeps the
// current grantee across a handshake while it still requests.
module rr_arb_idx
  import rr_arb_pkg::*;
#(
  parameter int NUM_REQ = RR_ARB_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  output logic               gnt_valid_o,
  input  logic               gnt_ready_i,
  output logic [IDX_W-1:0]   gnt_idx_o
`ifdef RR_ARB_LOCK_EN
  ,
  input  logic               lock_i
`endif
);

  rr_arb_state_t    state_q, state_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic             handshake;
  logic             lock_hold;
  logic [IDX_W-1:0] ptr_rot;
  logic [IDX_W-1:0] ptr_sel;
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;

  // Pointer after the current grant is accepted, and which pointer the search uses.
  always_comb begin
    handshake = gnt_valid_q & gnt_ready_i;
    ptr_rot   = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
`ifdef RR_ARB_LOCK_EN
    lock_hold = lock_i & req_i[gnt_idx_q];
`else
    lock_hold = 1'b0;
`endif
    ptr_sel   = handshake ? ptr_rot : ptr_q;
  end

  rr_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req (req_i),
    .ptr (ptr_sel),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Next-state logic: load a grant from IDLE, hold it until accepted, then rotate or lock.
  always_comb begin
    state_d     = state_q;
    gnt_valid_d = gnt_valid_q;
    gnt_idx_d   = gnt_idx_q;
    ptr_d       = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_idx_d   = pick_idx;
          gnt_valid_d = 1'b1;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (handshake) begin
          if (lock_hold) begin
            gnt_idx_d = gnt_idx_q;
          end else begin
            ptr_d = ptr_rot;
            if (pick_any) begin
              gnt_idx_d = pick_idx;
            end else begin
              gnt_valid_d = 1'b0;
              state_d     = IDLE;
            end
          end
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset clears the grant so the decoder sees index 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_idx_q   <= gnt_idx_d;
      ptr_q       <= ptr_d;
    end
  end

  assign gnt_valid_o = gnt_valid_q;
  assign gnt_idx_o   = gnt_idx_q;

endmodule
